// File: rtl/noc_dma_master_if_pkg.sv
// rtl/noc_dma_master_if_pkg.sv - shared types, flit field map and id widths for the DMA NoC initiator
package noc_dma_master_if_pkg;

    localparam int NODE_W = 4;
    localparam int SEQ_W  = 8;
    localparam int TAG_W  = SEQ_W + NODE_W;

    // read request (ctrl out)
    localparam int RQ_FLAG_BIT    = 5;
    localparam int RQ_TAG_LSB     = 7;
    localparam int RQ_ADDR_LSB    = 19;
    localparam int RQ_LEN_LSB     = 69;
    localparam int RQ_GRP_SEL_BIT = 254;

    // read response head (data in)
    localparam int RH_TAG_LSB       = 0;
    localparam int RH_HEAD_MARK_BIT = 12;
    localparam int RH_FLAG_BIT      = 13;

    // write head (data out)
    localparam int WH_FLAG_BIT = 13;
    localparam int WH_NODE_LSB = 14;
    localparam int WH_ADDR_LSB = 18;
    localparam int WH_LEN_LSB  = 43;

    // write response (ctrl in)
    localparam int WS_NODE_LSB      = 0;
    localparam int WS_HEAD_MARK_BIT = 4;
    localparam int WS_FLAG_BIT      = 5;

    localparam logic [NODE_W-1:0] NODE_ID_DEFAULT = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_HEAD,
        ST_RD_DATA,
        ST_WR_HEAD,
        ST_WR_DATA,
        ST_WR_RESP
    } state_t;

    function automatic logic [TAG_W-1:0] make_tag(input logic [SEQ_W-1:0] seq,
                                                  input logic [NODE_W-1:0] node);
        return {seq, node};
    endfunction

endpackage

// File: rtl/noc_dma_master_if_if.sv
// rtl/noc_dma_master_if_if.sv - the four NoC router channels between initiator and router port
interface noc_dma_master_if_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  ctrl_out_valid;
    logic [DATA_WIDTH-1:0] ctrl_out_flit;
    logic                  ctrl_out_last;
    logic                  ctrl_out_ready;

    logic                  ctrl_in_valid;
    logic [DATA_WIDTH-1:0] ctrl_in_flit;
    logic                  ctrl_in_last;
    logic                  ctrl_in_ready;

    logic                  data_out_valid;
    logic [DATA_WIDTH-1:0] data_out_flit;
    logic                  data_out_last;
    logic                  data_out_ready;

    logic                  data_in_valid;
    logic [DATA_WIDTH-1:0] data_in_flit;
    logic                  data_in_last;
    logic                  data_in_ready;

    modport master (
        output ctrl_out_valid, ctrl_out_flit, ctrl_out_last,
        input  ctrl_out_ready,
        input  ctrl_in_valid, ctrl_in_flit, ctrl_in_last,
        output ctrl_in_ready,
        output data_out_valid, data_out_flit, data_out_last,
        input  data_out_ready,
        input  data_in_valid, data_in_flit, data_in_last,
        output data_in_ready
    );

    modport slave (
        input  ctrl_out_valid, ctrl_out_flit, ctrl_out_last,
        output ctrl_out_ready,
        output ctrl_in_valid, ctrl_in_flit, ctrl_in_last,
        input  ctrl_in_ready,
        input  data_out_valid, data_out_flit, data_out_last,
        output data_out_ready,
        output data_in_valid, data_in_flit, data_in_last,
        input  data_in_ready
    );

endinterface

// File: rtl/noc_dma_master_if_flit_codec.sv
// rtl/noc_dma_master_if_flit_codec.sv - builds request/head flits and checks response/head flits
module noc_dma_flit_codec
    import noc_dma_master_if_pkg::*;
#(
    parameter int                DATA_WIDTH = 256,
    parameter logic [NODE_W-1:0] NODE_ID    = NODE_ID_DEFAULT,
    parameter int                LEN_W      = 13,
    parameter int                ADDR_W     = 25
) (
    input  logic [SEQ_W-1:0]       seq,
    input  logic                   flag,
    input  logic                   grp_sel,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [LEN_W-1:0]       len,
    output logic [DATA_WIDTH-1:0]  rd_req_flit,
    output logic [DATA_WIDTH-1:0]  wr_head_flit,
    input  logic [TAG_W-1:0]       exp_tag,
    input  logic                   exp_flag,
    input  logic [RH_FLAG_BIT:0]   rd_head_bits,
    input  logic [WS_FLAG_BIT:0]   wr_resp_bits,
    output logic                   rd_head_ok,
    output logic                   wr_resp_ok
);

    always_comb begin
        rd_req_flit                              = '0;
        rd_req_flit[RQ_FLAG_BIT]                 = flag;
        rd_req_flit[RQ_TAG_LSB +: TAG_W]         = make_tag(seq, NODE_ID);
        rd_req_flit[RQ_ADDR_LSB +: ADDR_W]       = addr;
        rd_req_flit[RQ_LEN_LSB +: LEN_W]         = len;
        rd_req_flit[RQ_GRP_SEL_BIT]              = grp_sel;
    end

    always_comb begin
        wr_head_flit                             = '0;
        wr_head_flit[WH_FLAG_BIT]                = flag;
        wr_head_flit[WH_NODE_LSB +: NODE_W]      = NODE_ID;
        wr_head_flit[WH_ADDR_LSB +: ADDR_W]      = addr;
        wr_head_flit[WH_LEN_LSB +: LEN_W]        = len;
    end

    assign rd_head_ok = (rd_head_bits[RH_TAG_LSB +: TAG_W] == exp_tag)
                      && rd_head_bits[RH_HEAD_MARK_BIT]
                      && (rd_head_bits[RH_FLAG_BIT] == exp_flag);

    assign wr_resp_ok = (wr_resp_bits[WS_NODE_LSB +: NODE_W] == NODE_ID)
                      && wr_resp_bits[WS_HEAD_MARK_BIT]
                      && (wr_resp_bits[WS_FLAG_BIT] == exp_flag);

endmodule

// File: rtl/noc_dma_master_if.sv
// rtl/noc_dma_master_if.sv - core-side NoC initiator turning local DMA commands into NoC reads/writes
module noc_dma_master_if #(
    parameter int         DATA_WIDTH = 256,
    parameter logic [3:0] NODE_ID    = 4'd0,
    parameter int         LEN_W      = 13,
    parameter int         ADDR_W     = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_grp_sel,
    input  logic                  cmd_flag,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    output logic                  done,
    output logic                  err,

    noc_dma_master_if_if.master   noc
);
    import noc_dma_master_if_pkg::*;

    state_t                state;
    logic [SEQ_W-1:0]      seq_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  flag_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] hdr_q;
    logic                  cmd_ready_q;
    logic                  done_q;
    logic                  err_q;
    logic                  err_out_q;

    logic [DATA_WIDTH-1:0] rd_req_flit;
    logic [DATA_WIDTH-1:0] wr_head_flit;
    logic                  rd_head_ok;
    logic                  wr_resp_ok;

    logic st_rd_head, st_rd_data, st_wr_head, st_wr_data;
    logic cnt_at_len, cmd_fire, rd_beat, wr_beat, last_bad;

    noc_dma_flit_codec #(
        .DATA_WIDTH (DATA_WIDTH),
        .NODE_ID    (NODE_ID),
        .LEN_W      (LEN_W),
        .ADDR_W     (ADDR_W)
    ) u_codec (
        .seq          (seq_q),
        .flag         (cmd_flag),
        .grp_sel      (cmd_grp_sel),
        .addr         (cmd_addr),
        .len          (cmd_len),
        .rd_req_flit  (rd_req_flit),
        .wr_head_flit (wr_head_flit),
        .exp_tag      (tag_q),
        .exp_flag     (flag_q),
        .rd_head_bits (noc.data_in_flit[RH_FLAG_BIT:0]),
        .wr_resp_bits (noc.ctrl_in_flit[WS_FLAG_BIT:0]),
        .rd_head_ok   (rd_head_ok),
        .wr_resp_ok   (wr_resp_ok)
    );

    assign st_rd_head = (state == ST_RD_HEAD);
    assign st_rd_data = (state == ST_RD_DATA);
    assign st_wr_head = (state == ST_WR_HEAD);
    assign st_wr_data = (state == ST_WR_DATA);
    assign cnt_at_len = (cnt_q == len_q);
    assign cmd_fire   = cmd_valid && cmd_ready_q;
    assign rd_beat    = st_rd_data && noc.data_in_valid && rd_ready;
    assign wr_beat    = st_wr_data && wr_valid && noc.data_out_ready;
    assign last_bad   = (noc.data_in_last != cnt_at_len);

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_out_q;

    // Data beats pass straight through; only header flits come from the held register.
    assign noc.ctrl_out_valid = (state == ST_RD_REQ);
    assign noc.ctrl_out_flit  = hdr_q;
    assign noc.ctrl_out_last  = (state == ST_RD_REQ);
    assign noc.ctrl_in_ready  = (state == ST_WR_RESP);
    assign noc.data_out_valid = st_wr_head || (st_wr_data && wr_valid);
    assign noc.data_out_flit  = st_wr_data ? wr_data : hdr_q;
    assign noc.data_out_last  = st_wr_data && cnt_at_len;
    assign noc.data_in_ready  = st_rd_head || (st_rd_data && rd_ready);

    assign wr_ready = st_wr_data && noc.data_out_ready;
    assign rd_valid = st_rd_data && noc.data_in_valid;
    assign rd_data  = noc.data_in_flit;
    assign rd_last  = st_rd_data && cnt_at_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            seq_q       <= '0;
            tag_q       <= '0;
            flag_q      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            hdr_q       <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_out_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready_q <= 1'b0;
                        seq_q       <= seq_q + 1'b1;
                        tag_q       <= make_tag(seq_q, NODE_ID);
                        flag_q      <= cmd_flag;
                        len_q       <= cmd_len;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        hdr_q       <= cmd_write ? wr_head_flit : rd_req_flit;
                        state       <= cmd_write ? ST_WR_HEAD : ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (noc.ctrl_out_ready) state <= ST_RD_HEAD;
                end
                ST_RD_HEAD: begin
                    if (noc.data_in_valid) begin
                        err_q <= err_q || !rd_head_ok;
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // The beat count decides the exit; a misplaced last only flags an error.
                    if (rd_beat) begin
                        if (cnt_at_len) begin
                            cnt_q       <= '0;
                            state       <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                            done_q      <= 1'b1;
                            err_out_q   <= err_q || last_bad;
                            err_q       <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            err_q <= err_q || last_bad;
                        end
                    end
                end
                ST_WR_HEAD: begin
                    if (noc.data_out_ready) state <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    if (wr_beat) begin
                        if (cnt_at_len) begin
                            cnt_q <= '0;
                            state <= ST_WR_RESP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (noc.ctrl_in_valid) begin
                        state       <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                        err_out_q   <= err_q || !wr_resp_ok;
                        err_q       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_dma_master_if.sv
// tb/tb_noc_dma_master_if.sv - directed self-checking bench for noc_dma_master_if
module tb_noc_dma_master_if;

    localparam int         DW  = 256;
    localparam logic [3:0] NID = 4'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write, cmd_grp_sel, cmd_flag;
    logic [24:0]   cmd_addr;
    logic [12:0]   cmd_len;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          done, err;

    noc_dma_master_if_if #(.DATA_WIDTH(DW)) noc ();

    noc_dma_master_if #(
        .DATA_WIDTH (DW),
        .NODE_ID    (NID),
        .LEN_W      (13),
        .ADDR_W     (25)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_grp_sel (cmd_grp_sel),
        .cmd_flag    (cmd_flag),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .done        (done),
        .err         (err),
        .noc         (noc)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] seq_m = 8'd0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k, input int i);
        return {8{32'(k * 65536 + i)}};
    endfunction

    task automatic issue(input logic w, input logic [24:0] a, input logic [12:0] l,
                         input logic g, input logic f);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_grp_sel = g; cmd_flag = f;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        seq_m++;
    endtask

    task automatic do_read(input int k, input logic [24:0] a, input logic [12:0] l, input logic g,
                           input logic f, input int stall, input bit toggle, input bit bad_tag,
                           input logic exp_err);
        logic [7:0]    s;
        logic [DW-1:0] rq;
        int            n;
        int            i;
        s = seq_m;
        issue(1'b0, a, l, g, f);
        rq = '0;
        rq[5] = f; rq[18:7] = {s, NID}; rq[43:19] = a; rq[81:69] = l; rq[254] = g;
        chk("rq_valid", noc.ctrl_out_valid, 1);
        chk("rq_flit", noc.ctrl_out_flit, rq);
        chk("rq_last", noc.ctrl_out_last, 1);
        repeat (stall) begin
            @(negedge clk);
            chk("rq_hold_valid", noc.ctrl_out_valid, 1);
            chk("rq_hold_flit", noc.ctrl_out_flit, rq);
        end
        noc.ctrl_out_ready = 1'b1;
        @(negedge clk);
        noc.ctrl_out_ready = 1'b0;
        chk("hd_ready", noc.data_in_ready, 1);
        noc.data_in_valid = 1'b1;
        noc.data_in_flit = '0;
        noc.data_in_flit[11:0] = {(bad_tag ? s + 8'd1 : s), NID};
        noc.data_in_flit[12] = 1'b1;
        noc.data_in_flit[13] = f;
        noc.data_in_last = 1'b0;
        @(negedge clk);
        i = 0;
        n = 0;
        while (i <= int'(l) && n < 4 * int'(l) + 20) begin
            noc.data_in_valid = 1'b1;
            noc.data_in_flit = pat(k, i);
            noc.data_in_last = (i == int'(l));
            rd_ready = toggle ? n[0] : 1'b1;
            #1;
            chk("rd_valid", rd_valid, 1);
            chk("in_ready", noc.data_in_ready, rd_ready);
            if (rd_ready) begin
                chk("rd_data", rd_data, pat(k, i));
                chk("rd_last", rd_last, (i == int'(l)));
                i++;
            end
            @(negedge clk);
            n++;
        end
        noc.data_in_valid = 1'b0;
        noc.data_in_last = 1'b0;
        rd_ready = 1'b0;
        chk("rd_beats", i, int'(l) + 1);
        chk("rd_done", done, 1);
        chk("rd_err", err, exp_err);
        @(negedge clk);
        chk("rd_done_pulse", done, 0);
        chk("rd_err_pulse", err, 0);
        chk("rd_idle_ready", cmd_ready, 1);
    endtask

    task automatic do_write(input int k, input logic [24:0] a, input logic [12:0] l, input logic f,
                            input logic resp_flag, input int stall, input int rst_beat,
                            input logic exp_err);
        logic [DW-1:0] hd;
        int            n;
        int            i;
        issue(1'b1, a, l, 1'b0, f);
        hd = '0;
        hd[13] = f; hd[17:14] = NID; hd[42:18] = a; hd[55:43] = l;
        chk("wh_valid", noc.data_out_valid, 1);
        chk("wh_flit", noc.data_out_flit, hd);
        chk("wh_last", noc.data_out_last, 0);
        chk("wh_wr_ready", wr_ready, 0);
        repeat (stall) begin
            @(negedge clk);
            chk("wh_hold_valid", noc.data_out_valid, 1);
            chk("wh_hold_flit", noc.data_out_flit, hd);
        end
        noc.data_out_ready = 1'b1;
        @(negedge clk);
        i = 0;
        n = 0;
        while (i <= int'(l) && n < 4 * int'(l) + 20) begin
            wr_valid = 1'b1;
            wr_data = pat(k, i);
            noc.data_out_ready = 1'b1;
            #1;
            if (i == rst_beat) begin
                rst_n = 1'b0;
                #1;
                chk("rst_do_valid", noc.data_out_valid, 0);
                chk("rst_co_valid", noc.ctrl_out_valid, 0);
                chk("rst_di_ready", noc.data_in_ready, 0);
                chk("rst_ci_ready", noc.ctrl_in_ready, 0);
                chk("rst_wr_ready", wr_ready, 0);
                chk("rst_cmd_ready", cmd_ready, 0);
                chk("rst_done", done, 0);
                wr_valid = 1'b0;
                noc.data_out_ready = 1'b0;
                @(negedge clk);
                chk("rst_do_valid_edge", noc.data_out_valid, 0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_release_ready", cmd_ready, 1);
                seq_m = 8'd0;
                return;
            end
            chk("do_valid", noc.data_out_valid, 1);
            chk("do_flit", noc.data_out_flit, pat(k, i));
            chk("do_last", noc.data_out_last, (i == int'(l)));
            chk("wr_ready", wr_ready, 1);
            chk("ci_ready_early", noc.ctrl_in_ready, 0);
            i++;
            @(negedge clk);
            n++;
        end
        wr_valid = 1'b0;
        noc.data_out_ready = 1'b0;
        chk("wr_beats", i, int'(l) + 1);
        noc.ctrl_in_valid = 1'b1;
        noc.ctrl_in_flit = '0;
        noc.ctrl_in_flit[3:0] = NID;
        noc.ctrl_in_flit[4] = 1'b1;
        noc.ctrl_in_flit[5] = resp_flag;
        noc.ctrl_in_last = 1'b1;
        #1;
        chk("ci_ready", noc.ctrl_in_ready, 1);
        @(negedge clk);
        noc.ctrl_in_valid = 1'b0;
        noc.ctrl_in_last = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_err", err, exp_err);
        @(negedge clk);
        chk("wr_done_pulse", done, 0);
        chk("wr_idle_ready", cmd_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_grp_sel = 1'b0; cmd_flag = 1'b0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        noc.ctrl_out_ready = 1'b0;
        noc.ctrl_in_valid = 1'b0; noc.ctrl_in_flit = '0; noc.ctrl_in_last = 1'b0;
        noc.data_out_ready = 1'b0;
        noc.data_in_valid = 1'b0; noc.data_in_flit = '0; noc.data_in_last = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_co_valid", noc.ctrl_out_valid, 0);
        chk("reset_do_valid", noc.data_out_valid, 0);
        chk("reset_di_ready", noc.data_in_ready, 0);
        chk("reset_ci_ready", noc.ctrl_in_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);

        do_read(1, 25'h10, 13'd3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_write(2, 25'h123, 13'd0, 1'b1, 1'b1, 0, -1, 1'b0);
        do_read(3, 25'h1ABCDE, 13'd7, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        do_read(4, 25'h40, 13'd2, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        do_write(5, 25'h77, 13'd2, 1'b0, 1'b1, 3, -1, 1'b1);

        @(negedge clk);
        noc.data_in_valid = 1'b1;
        noc.ctrl_in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_di_ready", noc.data_in_ready, 0);
            chk("stray_ci_ready", noc.ctrl_in_ready, 0);
        end
        noc.data_in_valid = 1'b0;
        noc.ctrl_in_valid = 1'b0;

        do_write(6, 25'h200, 13'd4, 1'b0, 1'b0, 0, 2, 1'b0);
        do_read(7, 25'h300, 13'd1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 257; j++) begin
            do_read(100 + j, 25'(j * 3), 13'd0, j[0], j[1], 0, 1'b0, 1'b0, 1'b0);
        end

        do_read(8, 25'h1FFFFFF, 13'd8191, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
